// File: rtl/rr_sel6_sched_if.sv
// rr_sel6_sched_if: request/beat bus between six requesters, the scheduler and the downstream sink.
//   master: drives req_en, in_valid, in_last, in0..in5, out_ready; observes in_ready, sel, out_*.
//   slave : the scheduler side (mirror of master).
interface rr_sel6_sched_if #(parameter int WIDTH = 8);
  logic [5:0]       req_en;
  logic [5:0]       in_valid;
  logic [5:0]       in_last;
  logic [5:0]       in_ready;
  logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5;
  logic [2:0]       sel;
  logic             out_valid;
  logic             out_last;
  logic [2:0]       out_src;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  modport master (
    output req_en, in_valid, in_last, in0, in1, in2, in3, in4, in5, out_ready,
    input  in_ready, sel, out_valid, out_last, out_src, out_data
  );
  modport slave (
    input  req_en, in_valid, in_last, in0, in1, in2, in3, in4, in5, out_ready,
    output in_ready, sel, out_valid, out_last, out_src, out_data
  );
endinterface

// File: rtl/rr_sel6_sched.sv
// rr_sel6_sched: six-way round-robin packet scheduler; locks onto one requester until its last beat.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rr_sel6_sched_if (requests, per-requester beats, registered output beat)
module rr_sel6_sched #(parameter int WIDTH = 8) (
  input logic             clk,
  input logic             rst_n,
  rr_sel6_sched_if.slave  bus
);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t           r_state;
  logic [2:0]       r_ptr;
  logic [2:0]       r_sel;
  logic             r_out_valid;
  logic             r_out_last;
  logic [2:0]       r_out_src;
  logic [WIDTH-1:0] r_out_data;
  logic [5:0]       w_elig;
  logic [5:0]       w_ready;
  logic             w_free;
  logic             w_xfer;
  logic             w_last;
  logic [2:0]       w_pick;
  logic [3:0]       w_idx;
  logic [WIDTH-1:0] w_in [8];
  assign w_elig  = bus.in_valid & bus.req_en;
  assign w_free  = !r_out_valid || bus.out_ready;
  assign w_ready = (r_state == LOCK && w_free) ? 6'd1 << r_sel : 6'd0;
  assign w_xfer  = |(bus.in_valid & w_ready);
  assign w_last  = |(bus.in_last & w_ready);
  always_comb begin
    w_in[0] = bus.in0;
    w_in[1] = bus.in1;
    w_in[2] = bus.in2;
    w_in[3] = bus.in3;
    w_in[4] = bus.in4;
    w_in[5] = bus.in5;
    w_in[6] = '0;
    w_in[7] = '0;
  end
  // Walk the search order backwards so the candidate closest to ptr is written last and wins.
  always_comb begin
    w_pick = 3'd0;
    w_idx  = 4'd0;
    for (int k = 5; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + 4'(k);
      w_idx = (w_idx >= 4'd6) ? w_idx - 4'd6 : w_idx;
      if (w_elig[w_idx[2:0]]) w_pick = w_idx[2:0];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= 3'd0;
      r_sel       <= 3'd7;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_src   <= 3'd0;
      r_out_data  <= '0;
    end else begin
      if (r_state == IDLE) begin
        if (|w_elig) begin
          r_state <= LOCK;
          r_sel   <= w_pick;
        end
      end else if (w_xfer && w_last) begin
        r_state <= IDLE;
        r_sel   <= 3'd7;
        r_ptr   <= (r_sel == 3'd5) ? 3'd0 : r_sel + 3'd1;
      end
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_last  <= w_last;
        r_out_src   <= r_sel;
        r_out_data  <= w_in[r_sel];
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
  assign bus.in_ready  = w_ready;
  assign bus.sel       = r_sel;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.out_src   = r_out_src;
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_rr_sel6_sched.sv
// tb_rr_sel6_sched: vector table, directed corner sequences and random traffic against a reference model.
module tb_rr_sel6_sched;
  localparam int WIDTH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  rr_sel6_sched_if #(.WIDTH(WIDTH)) bus ();
  rr_sel6_sched #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int         m_owner;
  int         m_ptr;
  bit         m_ov;
  bit         m_last;
  int         m_src;
  logic [7:0] m_data;
  typedef struct {
    logic [5:0] v;
    logic [5:0] l;
    logic [7:0] d;
    logic [2:0] sel;
    logic [5:0] rdy;
    logic       ov;
    logic [7:0] od;
    logic       ol;
  } vec_t;
  vec_t tbl [6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] din(input int i);
    case (i)
      0: return bus.in0;
      1: return bus.in1;
      2: return bus.in2;
      3: return bus.in3;
      4: return bus.in4;
      default: return bus.in5;
    endcase
  endfunction
  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_ov = 0; m_last = 0; m_src = 0; m_data = 0;
  endtask
  task automatic set_all_data(input logic [7:0] d);
    bus.in0 = d; bus.in1 = d; bus.in2 = d; bus.in3 = d; bus.in4 = d; bus.in5 = d;
  endtask
  // One clock: compare DUT against model, then advance the model from the applied inputs.
  task automatic cyc();
    bit was_idle;
    bit free;
    bit xfer;
    logic [5:0] exp_rdy;
    #1;
    free = !m_ov || bus.out_ready;
    exp_rdy = (m_owner >= 0 && free) ? 6'(1 << m_owner) : 6'd0;
    chk("sel", 32'(bus.sel), (m_owner < 0) ? 32'd7 : 32'(m_owner));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data", 32'(bus.out_data), 32'(m_data));
    chk("out_last", 32'(bus.out_last), 32'(m_last));
    chk("out_src", 32'(bus.out_src), 32'(m_src));
    was_idle = (m_owner < 0);
    xfer = !was_idle && free && bus.in_valid[m_owner];
    if (xfer) begin
      m_ov = 1; m_data = din(m_owner); m_last = bus.in_last[m_owner]; m_src = m_owner;
      if (m_last) begin
        m_ptr = (m_owner + 1) % 6;
        m_owner = -1;
      end
    end else if (bus.out_ready) begin
      m_ov = 0;
    end
    if (was_idle) begin
      for (int k = 0; k < 6; k++) begin
        int i;
        i = (m_ptr + k) % 6;
        if (bus.in_valid[i] && bus.req_en[i]) begin
          m_owner = i;
          break;
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel"}, 32'(bus.sel), 32'd7);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ol"}, 32'(bus.out_last), 32'd0);
    chk({tag, "_src"}, 32'(bus.out_src), 32'd0);
    chk({tag, "_data"}, 32'(bus.out_data), 32'd0);
  endtask
  task automatic do_reset();
    bus.req_en = 6'h3F; bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 1;
    set_all_data(8'h00);
    rst_n = 0;
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    model_reset();
    rst_n = 1;
  endtask
  initial begin
    tbl[0] = '{v: 6'h04, l: 6'h00, d: 8'hA1, sel: 3'd7, rdy: 6'h00, ov: 0, od: 8'h00, ol: 0};
    tbl[1] = '{v: 6'h04, l: 6'h00, d: 8'hA1, sel: 3'd2, rdy: 6'h04, ov: 0, od: 8'h00, ol: 0};
    tbl[2] = '{v: 6'h04, l: 6'h00, d: 8'hA2, sel: 3'd2, rdy: 6'h04, ov: 1, od: 8'hA1, ol: 0};
    tbl[3] = '{v: 6'h04, l: 6'h04, d: 8'hA3, sel: 3'd2, rdy: 6'h04, ov: 1, od: 8'hA2, ol: 0};
    tbl[4] = '{v: 6'h00, l: 6'h00, d: 8'h00, sel: 3'd7, rdy: 6'h00, ov: 1, od: 8'hA3, ol: 1};
    tbl[5] = '{v: 6'h00, l: 6'h00, d: 8'h00, sel: 3'd7, rdy: 6'h00, ov: 0, od: 8'hA3, ol: 1};
    model_reset();
    do_reset();
    // Single requester, three-beat packet
    for (int n = 0; n < 6; n++) begin
      bus.in_valid = tbl[n].v; bus.in_last = tbl[n].l; bus.in2 = tbl[n].d;
      #1;
      chk("tbl_sel", 32'(bus.sel), 32'(tbl[n].sel));
      chk("tbl_rdy", 32'(bus.in_ready), 32'(tbl[n].rdy));
      chk("tbl_ov", 32'(bus.out_valid), 32'(tbl[n].ov));
      if (tbl[n].ov) begin
        chk("tbl_data", 32'(bus.out_data), 32'(tbl[n].od));
        chk("tbl_last", 32'(bus.out_last), 32'(tbl[n].ol));
        chk("tbl_src", 32'(bus.out_src), 32'd2);
      end
      cyc();
    end
    // Round-robin fairness with one-beat packets from everyone
    do_reset();
    bus.in_valid = 6'h3F; bus.in_last = 6'h3F;
    for (int i = 1; i <= 14; i++) begin
      cyc();
      chk("rr_order", 32'(bus.sel), (i % 2) ? 32'((i - 1) / 2 % 6) : 32'd7);
    end
    // Back-pressure mid-packet
    do_reset();
    bus.in_valid = 6'h08; bus.in_last = 0; bus.in3 = 8'h10;
    cyc(); cyc();
    bus.in3 = 8'h11; bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_hold", 32'(bus.out_data), 32'h10);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1;
    cyc();
    chk("bp_next", 32'(bus.out_data), 32'h11);
    bus.in3 = 8'h12; bus.in_last = 6'h08;
    cyc();
    chk("bp_final", 32'(bus.out_data), 32'h12);
    chk("bp_final_last", 32'(bus.out_last), 32'd1);
    bus.in_valid = 0; bus.in_last = 0;
    cyc();
    // Mask: ptr=3, requester 3 disabled
    do_reset();
    bus.in_valid = 6'h04; bus.in_last = 6'h04;
    cyc(); cyc();
    bus.req_en = 6'b110111; bus.in_valid = 6'h18; bus.in_last = 6'h18;
    cyc();
    chk("mask_grant", 32'(bus.sel), 32'd4);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("mask_never3", 32'(bus.sel == 3'd3), 32'd0);
    end
    // Lock hold while owner drops valid
    do_reset();
    bus.in_valid = 6'b100010; bus.in_last = 0;
    cyc(); cyc();
    bus.in_valid = 6'b100000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lock_hold", 32'(bus.sel), 32'd1);
    end
    bus.in_valid = 6'b100010; bus.in_last = 6'b000010;
    cyc();
    chk("lock_release", 32'(bus.sel), 32'd7);
    cyc();
    chk("lock_next", 32'(bus.sel), 32'd5);
    // Reset mid-packet, then ties go to requester 0
    do_reset();
    bus.in_valid = 6'h01; bus.in_last = 0; bus.in0 = 8'h55;
    cyc(); cyc();
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    model_reset();
    rst_n = 1;
    bus.in_valid = 6'h3F; bus.in_last = 6'h3F;
    cyc();
    chk("post_reset_grant", 32'(bus.sel), 32'd0);
    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.req_en    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F;
      bus.in_valid  = 6'($urandom);
      bus.in_last   = 6'($urandom) & 6'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in0 = 8'($urandom); bus.in1 = 8'($urandom); bus.in2 = 8'($urandom);
      bus.in3 = 8'($urandom); bus.in4 = 8'($urandom); bus.in5 = 8'($urandom);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_sel6_sched.md
RR_SEL6_SCHED -- requirements
Module: rr_sel6_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data beat width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-004 SHALL have port req_en, input, 6, per-requester enable mask (bit i=1 allows requester i to win arbitration).
REQ-005 SHALL have port in_valid, input, 6, per-requester beat valid.
REQ-006 SHALL have port in_last, input, 6, per-requester last-beat-of-packet flag, qualified by in_valid.
REQ-007 SHALL have ports in0..in5, input, WIDTH each, per-requester beat data.
REQ-008 SHALL have port in_ready, output, 6, per-requester beat accept.
REQ-009 SHALL have port sel, output, 3, current owner index 0..5; 3'd7 when no owner (null).
REQ-010 SHALL have ports out_valid (1), out_last (1), out_src (3), out_data (WIDTH), all outputs, forming the registered output beat.
REQ-011 SHALL have port out_ready, input, 1, downstream accept.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no owner) and LOCK (owner held until its last beat transfers).
REQ-013 In IDLE, eligible = in_valid & req_en; if non-zero, SHALL pick the first eligible index searching ptr, ptr+1, ... wrapping 5->0, and enter LOCK next cycle with owner = that index.
REQ-014 In IDLE, with eligible all zero, SHALL remain in IDLE; ptr unchanged.
REQ-015 sel SHALL equal owner in LOCK and 3'd7 in IDLE; sel is registered (no combinational path from in_valid).
REQ-016 Output slot free = !out_valid | out_ready.
REQ-017 in_ready[i] SHALL be 1 only when state=LOCK, i=owner, and slot free; all other bits 0.
REQ-018 A transfer occurs when in_valid[owner] & in_ready[owner]; on transfer out_data, out_last, out_src SHALL load the owner's data, last flag and index, and out_valid SHALL be 1 next cycle.
REQ-019 When out_valid & out_ready and no new transfer that cycle, out_valid SHALL clear next cycle; out_data/out_last/out_src hold.
REQ-020 Simultaneous drain and transfer in the same cycle SHALL replace the beat with no bubble (full throughput, one beat per cycle).
REQ-021 Output register contents SHALL not change while out_valid=1 and out_ready=0.
REQ-022 On a transfer with in_last[owner]=1, SHALL return to IDLE next cycle and set ptr = owner+1, wrapping 5->0.
REQ-023 Latency: eligible request in IDLE at cycle N -> sel valid and in_ready possible at N+1 -> out_valid at N+2.
REQ-024 Minimum gap between packets SHALL be one IDLE cycle (the arbitration cycle).
REQ-025 Deasserting req_en[owner] or in_valid[owner] in LOCK SHALL NOT release ownership; lock ends only on the last-beat transfer.
REQ-026 Requester order within a packet SHALL be preserved; beats from different owners SHALL never interleave.

Reset
REQ-027 While rst_n=0 SHALL force: state=IDLE, ptr=0, sel=3'd7, in_ready=0, out_valid=0, out_last=0, out_src=0, out_data=0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet immediately; the first post-reset arbitration starts from ptr=0.
REQ-029 No output beat SHALL be produced in the first cycle after rst_n deasserts.

Verification
REQ-030 Single requester: req_en=6'h3F, in_valid[2] with 3 beats A1,A2,A3(last), out_ready=1 -> sel=2 from cycle 1, out_data A1,A2,A3 on consecutive cycles 2-4, out_src=2, out_last only on A3, then sel=7.
REQ-031 Round-robin fairness: all six valid with 1-beat packets continuously -> grant order 0,1,2,3,4,5,0 with one IDLE cycle between grants.
REQ-032 Back-pressure: out_ready=0 for 4 cycles mid-packet -> out_data held, in_ready[owner]=0, no beat lost or duplicated after out_ready returns to 1.
REQ-033 Mask: req_en=6'b110111, requesters 3 and 4 valid, ptr=3 -> owner 4 granted; requester 3 never granted.
REQ-034 Lock hold: owner 1 drops in_valid for 3 cycles mid-packet while requester 5 is valid -> sel stays 1, packet completes, then 5 is granted.
REQ-035 Reset mid-packet: rst_n low during beat 2 of 4 -> all outputs at reset values asynchronously; after release, requester 0 wins ties.
